// File: rtl/spi_seq_pkg.sv
// Shared constants and FSM state type for the SPI APB sequencer.
package spi_seq_pkg;

  localparam logic [7:0] ADDR_CR1 = 8'h00;
  localparam logic [7:0] ADDR_BDR = 8'h08;
  localparam logic [7:0] ADDR_SR  = 8'h0C;
  localparam logic [7:0] ADDR_DR  = 8'h10;

  localparam int unsigned SR_TXCR   = 2;
  // SPE | MSTR: the peripheral is always enabled as master.
  localparam logic [7:0]  CR1_FORCE = 8'h18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CFG_CR1,
    S_CFG_BDR,
    S_WR_DATA,
    S_POLL,
    S_RD_DATA,
    S_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [IW-1:0]   ptr_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  int unsigned c;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/spi_apb_sequencer.sv
// APB master serialising byte transfers from NREQ clients onto one SPI peripheral,
// reprogramming CR1/BDR only when the winner's settings differ from the shadow copy.
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int unsigned NREQ     = 2,
  parameter  int unsigned addr     = 32,
  parameter  int unsigned data     = 32,
  parameter  int unsigned POLL_MAX = 1024,
  localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_cr1,
  input  logic [NREQ*8-1:0] req_bdr,
  input  logic [NREQ*8-1:0] req_tx,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rx,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [addr-1:0]   PADDR,
  output logic [data-1:0]   PWDATA,
  input  logic [data-1:0]   PRDATA
);

  localparam int unsigned CW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  state_e          state_q;
  logic            phase_q;
  logic [IW-1:0]   g_q;
  logic [NREQ-1:0] goh_q;
  logic [IW-1:0]   ptr_q;
  logic            cfg_valid_q;
  logic [7:0]      cr1_q;
  logic [7:0]      bdr_q;
  logic [CW-1:0]   pcnt_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] err_q;
  logic [7:0]      rx_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [addr-1:0] paddr_q;
  logic [data-1:0] pwdata_q;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_valid;

  logic [7:0] cr1_sel;
  logic [7:0] bdr_sel;
  logic [7:0] tx_sel;
  logic [7:0] cr1_d;
  logic [IW-1:0] ptr_d;

  logic unused_prdata;
  assign unused_prdata = ^PRDATA[data-1:8];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .ptr_i  (ptr_q),
    .req_i  (req),
    .gnt_o  (win_oh),
    .idx_o  (win_idx),
    .valid_o(win_valid)
  );

  always_comb begin
    cr1_sel = '0;
    bdr_sel = '0;
    tx_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (g_q == IW'(i)) begin
        cr1_sel = req_cr1[8*i +: 8];
        bdr_sel = req_bdr[8*i +: 8];
        tx_sel  = req_tx[8*i +: 8];
      end
    end
  end

  assign cr1_d = cr1_sel | CR1_FORCE;
  assign ptr_d = (g_q == IW'(NREQ-1)) ? '0 : g_q + IW'(1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      g_q         <= '0;
      goh_q       <= '0;
      ptr_q       <= '0;
      cfg_valid_q <= 1'b0;
      cr1_q       <= '0;
      bdr_q       <= '0;
      pcnt_q      <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rx_q        <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            g_q     <= win_idx;
            goh_q   <= win_oh;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
          phase_q   <= 1'b0;
          pwrite_q  <= 1'b1;
          if (!cfg_valid_q || cr1_d != cr1_q || bdr_sel != bdr_q) begin
            state_q  <= S_CFG_CR1;
            paddr_q  <= addr'(ADDR_CR1);
            pwdata_q <= data'(cr1_d);
          end else begin
            state_q  <= S_WR_DATA;
            paddr_q  <= addr'(ADDR_DR);
            pwdata_q <= data'(tx_sel);
          end
        end
        S_CFG_CR1, S_CFG_BDR, S_WR_DATA, S_POLL, S_RD_DATA: begin
          // Shared SETUP->ACCESS step; the per-state work below happens at ACCESS
          // and sets up the next SETUP so PSEL never drops between accesses.
          if (!phase_q) begin
            phase_q   <= 1'b1;
            penable_q <= 1'b1;
          end else begin
            phase_q   <= 1'b0;
            penable_q <= 1'b0;
            case (state_q)
              S_CFG_CR1: begin
                cr1_q    <= cr1_d;
                state_q  <= S_CFG_BDR;
                paddr_q  <= addr'(ADDR_BDR);
                pwdata_q <= data'(bdr_sel);
              end
              S_CFG_BDR: begin
                bdr_q       <= bdr_sel;
                cfg_valid_q <= 1'b1;
                state_q     <= S_WR_DATA;
                paddr_q     <= addr'(ADDR_DR);
                pwdata_q    <= data'(tx_sel);
              end
              S_WR_DATA: begin
                state_q  <= S_POLL;
                pwrite_q <= 1'b0;
                paddr_q  <= addr'(ADDR_SR);
                pwdata_q <= '0;
                pcnt_q   <= '0;
              end
              S_POLL: begin
                if (PRDATA[SR_TXCR]) begin
                  state_q <= S_RD_DATA;
                  paddr_q <= addr'(ADDR_DR);
                end else if (pcnt_q == CW'(POLL_MAX-1)) begin
                  err_q   <= goh_q;
                  ptr_q   <= ptr_d;
                  psel_q  <= 1'b0;
                  state_q <= S_IDLE;
                end else begin
                  pcnt_q <= pcnt_q + CW'(1);
                end
              end
              default: begin
                rx_q    <= PRDATA[7:0];
                ack_q   <= goh_q;
                psel_q  <= 1'b0;
                state_q <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign rx      = rx_q;
  assign busy    = (state_q != S_IDLE);
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Directed bench for spi_apb_sequencer with a behavioural APB/SPI slave.
module tb_spi_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req;
  logic [15:0] req_cr1, req_bdr, req_tx;
  logic [1:0]  ack, err;
  logic [7:0]  rx;
  logic        busy, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;

  spi_apb_sequencer #(.NREQ(2), .addr(32), .data(32), .POLL_MAX(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_cr1(req_cr1), .req_bdr(req_bdr),
    .req_tx(req_tx), .ack(ack), .err(err), .rx(rx), .busy(busy), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } apb_t;

  typedef struct {
    int         r;
    logic [7:0] cr1;
    logic [7:0] bdr;
    logic [7:0] tx;
    int         polls;
    logic [7:0] slave;
    bit         cfg;
    int         lat;
  } vec_t;

  apb_t log_q[$];
  int   polls_seen = 0;
  int   txcr_on    = 0;
  logic [7:0] slave_byte = 8'h00;
  int   nvec = 0;
  int   nfail = 0;

  // Slave: status reports TXCR from the txcr_on-th poll of each transfer (0 = never).
  assign PRDATA = (PADDR == 32'h0C) ?
                    ((txcr_on != 0 && polls_seen + 1 >= txcr_on) ? 32'h0000_0004 : 32'hFFFF_FFFB) :
                  (PADDR == 32'h10) ? {24'h5A5A5A, slave_byte} : 32'hDEAD_BEEF;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE) begin
      log_q.push_back('{wr: PWRITE, a: PADDR, d: PWDATA});
      if (PWRITE && PADDR == 32'h10) polls_seen <= 0;
      else if (!PWRITE && PADDR == 32'h0C) polls_seen <= polls_seen + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input int start, output int cyc, output bit got);
    cyc = start;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(posedge PCLK); #1;
      cyc++;
      if (ack != 0 || err != 0) got = 1'b1;
    end
  endtask

  task automatic set_req(input int r, input logic [7:0] cr1, input logic [7:0] bdr, input logic [7:0] tx);
    req_cr1[8*r +: 8] = cr1;
    req_bdr[8*r +: 8] = bdr;
    req_tx[8*r +: 8]  = tx;
  endtask

  task automatic run_txn(input vec_t v);
    int   cyc;
    bit   got;
    apb_t exp_q[$];
    logic [1:0] oh;
    @(negedge PCLK);
    chk("idle_before", {63'b0, busy}, 64'd0);
    log_q.delete();
    txcr_on    = v.polls;
    slave_byte = v.slave;
    set_req(v.r, v.cr1, v.bdr, v.tx);
    oh = 2'b01 << v.r;
    req = oh;
    wait_pulse(1, cyc, got);
    req = '0;
    chk("ack_seen", {63'b0, got}, 64'd1);
    chk("ack_onehot", {62'b0, ack}, {62'b0, oh});
    chk("no_err", {62'b0, err}, 64'd0);
    chk("latency", 64'(cyc), 64'(v.lat));
    chk("rx", {56'b0, rx}, {56'b0, v.slave});
    if (v.cfg) begin
      exp_q.push_back('{wr: 1'b1, a: 32'h00, d: {24'b0, v.cr1 | 8'h18}});
      exp_q.push_back('{wr: 1'b1, a: 32'h08, d: {24'b0, v.bdr}});
    end
    exp_q.push_back('{wr: 1'b1, a: 32'h10, d: {24'b0, v.tx}});
    for (int i = 0; i < v.polls; i++) exp_q.push_back('{wr: 1'b0, a: 32'h0C, d: 32'h0});
    exp_q.push_back('{wr: 1'b0, a: 32'h10, d: 32'h0});
    chk("apb_count", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("apb_addr", {31'b0, log_q[i].wr, log_q[i].a}, {31'b0, exp_q[i].wr, exp_q[i].a});
      if (exp_q[i].wr) chk("apb_wdata", {32'b0, log_q[i].d}, {32'b0, exp_q[i].d});
    end
    @(posedge PCLK); #1;
    chk("ack_width", {62'b0, ack}, 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int   cyc;
    bit   got;
    int   nsr;
    int   ncfg;
    vec_t v;

    // r, cr1, bdr, tx, polls, slave, cfg, latency (IDLE cycle = 1)
    tbl[0] = '{0, 8'h04, 8'h03, 8'hA5, 3, 8'h5A, 1'b1, 17};
    tbl[1] = '{0, 8'h04, 8'h03, 8'h3C, 1, 8'hC3, 1'b0, 9};
    tbl[2] = '{1, 8'h04, 8'h07, 8'h11, 2, 8'h22, 1'b1, 15};
    tbl[3] = '{1, 8'h0C, 8'h07, 8'h44, 1, 8'h99, 1'b0, 9};
    tbl[4] = '{1, 8'h80, 8'h07, 8'h66, 4, 8'h77, 1'b1, 19};
    tbl[5] = '{1, 8'h80, 8'h07, 8'h01, 1, 8'hFE, 1'b0, 9};

    PRESET  = 1'b1;
    req     = '0;
    req_cr1 = '0;
    req_bdr = '0;
    req_tx  = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", {63'b0, PSEL}, 64'd0);
    chk("rst_penable", {63'b0, PENABLE}, 64'd0);
    chk("rst_pwrite", {63'b0, PWRITE}, 64'd0);
    chk("rst_paddr", {32'b0, PADDR}, 64'd0);
    chk("rst_pwdata", {32'b0, PWDATA}, 64'd0);
    chk("rst_ack_err", {60'b0, ack, err}, 64'd0);
    chk("rst_rx", {56'b0, rx}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Contention: both requesters held, pointer is back at 0, config unchanged.
    @(negedge PCLK);
    log_q.delete();
    txcr_on    = 1;
    slave_byte = 8'h3E;
    set_req(0, 8'h80, 8'h07, 8'h10);
    set_req(1, 8'h80, 8'h07, 8'h20);
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_pulse(1, cyc, got);
      if (n == 3) req = '0;
      chk("cont_seen", {63'b0, got}, 64'd1);
      chk("cont_order", {62'b0, ack}, (n % 2 == 0) ? 64'd1 : 64'd2);
      chk("cont_spacing", 64'(cyc), 64'd9);
      @(posedge PCLK); #1;
      chk("cont_width", {62'b0, ack}, 64'd0);
    end
    ncfg = 0;
    foreach (log_q[i]) if (log_q[i].wr && log_q[i].a != 32'h10) ncfg++;
    chk("cont_no_cfg", 64'(ncfg), 64'd0);

    // Timeout: TXCR never set, POLL_MAX = 4.
    @(negedge PCLK);
    log_q.delete();
    txcr_on = 0;
    set_req(0, 8'h80, 8'h07, 8'h55);
    req = 2'b01;
    wait_pulse(1, cyc, got);
    req = '0;
    chk("to_seen", {63'b0, got}, 64'd1);
    chk("to_err", {62'b0, err}, 64'd1);
    chk("to_no_ack", {62'b0, ack}, 64'd0);
    chk("to_latency", 64'(cyc), 64'd13);
    chk("to_busy", {63'b0, busy}, 64'd0);
    chk("to_psel", {63'b0, PSEL}, 64'd0);
    nsr = 0;
    foreach (log_q[i]) if (!log_q[i].wr && log_q[i].a == 32'h0C) nsr++;
    chk("to_polls", 64'(nsr), 64'd4);
    chk("to_apb_count", 64'(log_q.size()), 64'd5);
    @(posedge PCLK); #1;
    chk("to_err_width", {62'b0, err}, 64'd0);

    // Reset while polling, then the next request must reprogram the SPI.
    @(negedge PCLK);
    txcr_on = 0;
    set_req(1, 8'h80, 8'h07, 8'h33);
    req = 2'b10;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(posedge PCLK); #1;
      if (PSEL && PENABLE && PADDR == 32'h0C) got = 1'b1;
    end
    chk("mr_in_poll", {63'b0, got}, 64'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    req    = '0;
    @(posedge PCLK); #1;
    chk("mr_psel", {63'b0, PSEL}, 64'd0);
    chk("mr_penable", {63'b0, PENABLE}, 64'd0);
    chk("mr_busy", {63'b0, busy}, 64'd0);
    chk("mr_no_ack", {62'b0, ack}, 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    v = '{0, 8'h80, 8'h07, 8'hC0, 1, 8'h0F, 1'b1, 13};
    run_txn(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/spi_apb_sequencer.md
# spi_apb_sequencer

APB master that shares the SPI peripheral among `NREQ` byte-transfer requesters. It arbitrates round-robin and programs the SPI control and baud registers only when the winner's settings differ from the last values written. It then writes the TX byte, polls the status register for completion, reads the RX byte back and acknowledges the requester. It sits between on-chip clients and the APB slave port of the SPI subsystem, replacing hand-written CPU driver sequences.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `addr`, 32: APB address width.
- `data`, 32: APB data width.
- `POLL_MAX`, 1024: maximum status polls before a timeout.

Ports:
- `PCLK` in 1: single clock.
- `PRESET` in 1: reset, synchronous, active-high.
- `req` in NREQ: per-requester request level; held high until `ack` or `err`.
- `req_cr1` in NREQ*8: SPICR_1 value per requester, slice i = bits [8i+7:8i].
- `req_bdr` in NREQ*8: SPIBDR value per requester.
- `req_tx` in NREQ*8: TX byte per requester.
- `ack` out NREQ: one-cycle pulse to the served requester on success.
- `err` out NREQ: one-cycle pulse to the served requester on poll timeout.
- `rx` out 8: RX byte; valid in the cycle `ack` pulses, held until the next `ack`.
- `busy` out 1: high whenever state ≠ IDLE.
- `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1: APB master controls.
- `PADDR` out addr: APB address.
- `PWDATA` out data: APB write data.
- `PRDATA` in data: APB read data, sampled in the ACCESS cycle.

## Operation
- Register map is fixed: SPICR_1 0x00, SPICR_2 0x04, SPIBDR 0x08, SPISR 0x0C, SPIDR 0x10.
- SPISR bit 2 (TXCR) means transfer complete.
- Every APB access takes exactly 2 cycles:
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - There is no PREADY.
- Write data is zero-extended to `data` bits.
- State machine: IDLE → GRANT → [CFG_CR1 → CFG_BDR] → WR_DATA → POLL → RD_DATA → DONE → IDLE. Each APB state contains a SETUP/ACCESS phase bit.
- **IDLE**: if any `req` is high, latch the winner index `g`; go to GRANT.
- **GRANT**:
  - If `req_cr1[g] | 8'h18` differs from shadow `cr1_q`, or `req_bdr[g]` differs from `bdr_q`, or `cfg_valid` = 0: go to CFG_CR1.
  - Otherwise go to WR_DATA.
- **CFG_CR1**: write `req_cr1[g] | 8'h18` to 0x00. SPE and MSTR are always forced to 1. Update `cr1_q`.
- **CFG_BDR**: write `req_bdr[g]` to 0x08. Update `bdr_q`; set `cfg_valid`.
- SPICR_2 is never written.
- **WR_DATA**: write `req_tx[g]` to 0x10.
- **POLL**:
  - Read 0x0C.
  - At ACCESS: if PRDATA[2] = 1, go to RD_DATA.
  - Else if poll count = POLL_MAX-1, pulse `err[g]` and go to IDLE.
  - Else re-issue SETUP.
- **RD_DATA**: read 0x10; capture PRDATA[7:0] into `rx`.
- **DONE**: pulse `ack[g]`; advance the round-robin pointer to g+1 (mod NREQ); go to IDLE.
- Arbitration: the winner is the first asserted `req` scanning from the pointer upward with wrap-around. The pointer also advances after an `err`.
- `req` changes after GRANT are ignored until the transaction ends. A requester dropping `req` mid-transaction does not abort it.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE = 0; PADDR = 0; PWDATA = 0.
  - `ack` = 0, `err` = 0, `rx` = 0, `busy` = 0.
  - Pointer = 0; `cfg_valid` = 0; `cr1_q` = 0; `bdr_q` = 0; poll counter = 0.
- PRESET mid-transaction: all APB outputs are 0 on the next cycle and there is no ack. The SPI is reprogrammed on the next request because `cfg_valid` = 0.
- Outputs are registered. PSEL rises the cycle after entering an APB state.
- Latency from `req` rising (seen in IDLE) to `ack`, with k polls: IDLE 1 + GRANT 1 + WR 2 + POLL 2k + RD 2 + DONE 1 = 7+2k cycles. Add 4 when reconfiguring.
- Between consecutive APB accesses, PSEL stays high. There are no idle cycles except GRANT/DONE/IDLE.
- Back-to-back: a new transaction can be granted on the cycle after DONE.
- Timeout: `err` fires 4+2·POLL_MAX cycles after GRANT on the no-reconfig path.

## Structure
- Package `spi_seq_pkg` holds the register address constants, the SPISR bit index (TXCR = 2), the CR1 force mask 8'h18 and the state enum.
- Sub-module `rr_arbiter` (NREQ, pointer in, req in, one-hot/index out) is combinational and is instantiated once.

## Test plan
- **Single request, cold start.** Requester 0 with cr1=0x04, bdr=0x03, tx=0xA5; TXCR set on the 3rd poll.
  - APB writes 0x00←0x1C, 0x08←0x03, 0x10←0xA5.
  - Three reads of 0x0C, then one read of 0x10.
  - `ack[0]` at cycle 17, `rx` = slave byte.
- **Config reuse.** Second request, same cfg, TX complete on the 1st poll.
  - No CFG writes.
  - `ack` exactly 9 cycles after the IDLE sample.
- **Contention.** `req` = 2'b11 held continuously; same cfg for both requesters.
  - Grants alternate 0,1,0,1.
  - Each ack pulses exactly one cycle.
- **Config switch.** Requester 1 with bdr=0x07 after requester 0 with bdr=0x03.
  - CFG_CR1 and CFG_BDR are reissued.
  - `bdr_q` = 0x07.
- **Timeout.** POLL_MAX=4, TXCR never set.
  - Exactly 4 status reads, then `err[g]` pulse, no `ack`, return to IDLE.
- **Mid-transaction reset.** PRESET asserted in POLL.
  - Next cycle: PSEL=0, `busy`=0.
  - Following request starts with CFG_CR1.
